abr_prim_intr_gateway: RTL and testbench

- Consumer-side counterpart to the per-block interrupt generators: collects Width interrupt lines, gates each source, arbitrates pending sources and offers one ID at a time to a servicing agent (µC/sequencer).
- The agent consumes the offer with a claim/complete handshake.
- Sits between the block interrupt outputs and the top-level interrupt pin.

---
 rtl/abr_prim_intr_gateway.sv | 126 ++++++++++++
 tb/tb_abr_prim_intr_gateway.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/abr_prim_intr_gateway.sv
// Interrupt gateway: gates per-source edge/level interrupts, arbitrates pending sources by
// lowest index and offers one ID at a time to a servicing agent via claim/complete.
module abr_prim_intr_gateway #(
    parameter int unsigned         Width    = 4,
    parameter logic [Width-1:0]    EdgeMask = '0,
    localparam int unsigned        IdW      = $clog2(Width)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] intr_i,
    input  logic [Width-1:0] enable_i,
    input  logic             claim_i,
    input  logic             complete_i,
    input  logic [IdW-1:0]   complete_id_i,
    output logic             irq_o,
    output logic [IdW-1:0]   claim_id_o,
    output logic [Width-1:0] pending_o,
    output logic [Width-1:0] in_service_o,
    output logic             err_o
);

    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e           r_state;
    logic [IdW-1:0]   r_claim_id;
    logic [Width-1:0] r_pending;
    logic [Width-1:0] r_in_service;
    logic [Width-1:0] r_prev;
    logic             r_err;

    state_e           w_state_d;
    logic [IdW-1:0]   w_claim_id_d;
    logic [Width-1:0] w_pending_d;
    logic [Width-1:0] w_in_service_d;
    logic             w_err_d;

    logic [Width-1:0] w_elig;
    logic [IdW-1:0]   w_lowest;
    logic [Width-1:0] w_offer_vec;
    logic [Width-1:0] w_claim_vec;
    logic [Width-1:0] w_cpl_vec;
    logic [Width-1:0] w_cpl_clr;
    logic [Width-1:0] w_edge_set;
    logic [Width-1:0] w_lvl_set;
    logic             w_claim;
    logic             w_offer_en;

    // One-hot decode; IDs at or above Width decode to all-zero (out of range).
    function automatic logic [Width-1:0] dec_id(input logic [IdW-1:0] id);
        logic [Width-1:0] v;
        v = '0;
        for (int i = 0; i < int'(Width); i++) begin
            if (id == IdW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        w_elig   = r_pending & enable_i;
        w_lowest = '0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (w_elig[i]) w_lowest = IdW'(i);
        end
    end

    always_comb begin
        w_offer_vec = dec_id(r_claim_id);
        w_cpl_vec   = dec_id(complete_id_i);
        w_offer_en  = |(enable_i & w_offer_vec);
        w_claim     = (r_state == StOffer) && claim_i;
        w_claim_vec = w_claim ? w_offer_vec : '0;
        w_cpl_clr   = complete_i ? (w_cpl_vec & r_in_service) : '0;

        w_edge_set  = EdgeMask & intr_i & ~r_prev;
        w_lvl_set   = ~EdgeMask & intr_i & ~r_pending & ~r_in_service;

        // Edge sets survive a same-cycle claim; level sets are blocked by it.
        w_pending_d    = ((r_pending | w_lvl_set) & ~w_claim_vec) | w_edge_set;
        w_in_service_d = (r_in_service & ~w_cpl_clr) | w_claim_vec;

        // A complete racing a claim of the same ID is not an error.
        w_err_d = complete_i && (w_cpl_clr == '0) && !(|(w_cpl_vec & w_claim_vec));
    end

    always_comb begin
        w_state_d    = r_state;
        w_claim_id_d = r_claim_id;
        unique case (r_state)
            StIdle: begin
                if (|w_elig) begin
                    w_state_d    = StOffer;
                    w_claim_id_d = w_lowest;
                end
            end
            StOffer: begin
                if (claim_i || !w_offer_en) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_claim_id   <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_prev       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_claim_id   <= w_claim_id_d;
            r_pending    <= w_pending_d;
            r_in_service <= w_in_service_d;
            r_prev       <= intr_i;
            r_err        <= w_err_d;
        end
    end

    assign irq_o        = (r_state == StOffer);
    assign claim_id_o   = r_claim_id;
    assign pending_o    = r_pending;
    assign in_service_o = r_in_service;
    assign err_o        = r_err;

endmodule

// File: tb/tb_abr_prim_intr_gateway.sv
// Directed bench: 4-source gateway with source 0 edge-triggered, plus a 3-source instance
// for out-of-range completes.
`timescale 1ns/1ps
module tb_abr_prim_intr_gateway;

    logic       clk;
    logic       rst;
    logic [3:0] intr, en;
    logic       claim, cpl;
    logic [1:0] cpl_id;
    logic       irq, err;
    logic [1:0] claim_id;
    logic [3:0] pend, insvc;

    logic [2:0] intr3, en3;
    logic       claim3, cpl3;
    logic [1:0] cpl_id3;
    logic       irq3, err3;
    logic [1:0] claim_id3;
    logic [2:0] pend3, insvc3;

    int n_checks = 0;
    int n_fail   = 0;

    abr_prim_intr_gateway #(.Width(4), .EdgeMask(4'b0001)) dut (
        .clk_i(clk), .rst_i(rst), .intr_i(intr), .enable_i(en), .claim_i(claim),
        .complete_i(cpl), .complete_id_i(cpl_id), .irq_o(irq), .claim_id_o(claim_id),
        .pending_o(pend), .in_service_o(insvc), .err_o(err)
    );

    abr_prim_intr_gateway #(.Width(3), .EdgeMask(3'b000)) dut3 (
        .clk_i(clk), .rst_i(rst), .intr_i(intr3), .enable_i(en3), .claim_i(claim3),
        .complete_i(cpl3), .complete_id_i(cpl_id3), .irq_o(irq3), .claim_id_o(claim_id3),
        .pending_o(pend3), .in_service_o(insvc3), .err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        rst = 1; intr = 4'hF; en = 4'hF; claim = 0; cpl = 0; cpl_id = 0;
        intr3 = 0; en3 = 3'b111; claim3 = 0; cpl3 = 0; cpl_id3 = 0;

        // Reset held with all lines high
        tick(); tick();
        check_eq("rst_irq", 32'(irq), 0);
        check_eq("rst_pend", 32'(pend), 0);
        check_eq("rst_insvc", 32'(insvc), 0);
        check_eq("rst_err", 32'(err), 0);
        rst = 0;
        tick();
        check_eq("rel_pend", 32'(pend), 32'hF);
        check_eq("rel_irq_early", 32'(irq), 0);
        tick();
        check_eq("rel_irq", 32'(irq), 1);
        check_eq("rel_id", 32'(claim_id), 0);

        rst = 1; intr = 4'h0;
        tick();
        rst = 0;
        tick();

        // Priority among level sources 1 and 3
        intr = 4'b1010;
        tick();
        check_eq("pri_pend", 32'(pend), 32'b1010);
        tick();
        check_eq("pri_irq", 32'(irq), 1);
        check_eq("pri_id1", 32'(claim_id), 1);
        claim = 1;
        tick();
        claim = 0;
        check_eq("pri_insvc1", 32'(insvc), 32'b0010);
        check_eq("pri_pend_after", 32'(pend), 32'b1000);
        check_eq("pri_irq_drop", 32'(irq), 0);
        tick();
        check_eq("pri_id3", 32'(claim_id), 3);
        check_eq("pri_irq3", 32'(irq), 1);
        claim = 1;
        tick();
        claim = 0; intr = 4'b0000; cpl = 1; cpl_id = 1;
        check_eq("pri_insvc13", 32'(insvc), 32'b1010);
        check_eq("pri_lvl_gated", 32'(pend), 0);
        tick();
        check_eq("cpl1_insvc", 32'(insvc), 32'b1000);
        check_eq("cpl1_err", 32'(err), 0);

        // Illegal completes: not in service, then out of range on 3-wide instance
        cpl_id = 2;
        tick();
        check_eq("ill2_err", 32'(err), 1);
        check_eq("ill2_insvc", 32'(insvc), 32'b1000);
        cpl_id = 3;
        tick();
        check_eq("cpl3_err", 32'(err), 0);
        check_eq("cpl3_insvc", 32'(insvc), 0);
        cpl3 = 1; cpl_id3 = 3;
        tick();
        cpl = 0; cpl3 = 0;
        check_eq("ill3_err", 32'(err), 1);
        check_eq("ill3_insvc", 32'(insvc), 0);
        check_eq("w3_err", 32'(err3), 1);
        check_eq("w3_insvc", 32'(insvc3), 0);
        tick();
        check_eq("ill3_err_pulse", 32'(err), 0);
        check_eq("w3_err_pulse", 32'(err3), 0);
        check_eq("w3_quiet", 32'({irq3, claim_id3, pend3}), 0);

        // Edge source 0: two pulses merge while disabled
        en = 4'b1110;
        intr = 4'b0001; tick();
        intr = 4'b0000; tick();
        intr = 4'b0001; tick();
        intr = 4'b0000; tick();
        check_eq("edge_merge", 32'(pend), 32'b0001);
        check_eq("edge_dis_irq", 32'(irq), 0);
        en = 4'hF;
        tick();
        check_eq("edge_offer", 32'({irq, claim_id}), 32'b100);
        claim = 1;
        tick();
        claim = 0; intr = 4'b0001;
        check_eq("edge_insvc", 32'(insvc), 32'b0001);
        check_eq("edge_pend_clr", 32'(pend), 0);
        tick();
        intr = 4'b0000;
        check_eq("edge_repend", 32'(pend), 32'b0001);
        tick();
        check_eq("edge_reoffer", 32'({irq, claim_id}), 32'b100);
        // Claim and complete of the same ID together: set wins, no error
        claim = 1; cpl = 1; cpl_id = 0;
        tick();
        claim = 0; cpl = 0;
        check_eq("race_insvc", 32'(insvc), 32'b0001);
        check_eq("race_err", 32'(err), 0);
        check_eq("race_irq", 32'(irq), 0);
        cpl = 1; cpl_id = 0;
        tick();
        cpl = 0;
        check_eq("edge_cpl0", 32'(insvc), 0);

        // Withdraw on enable drop, then enable drop racing a claim
        intr = 4'b0100;
        tick(); tick();
        check_eq("wd_offer", 32'({irq, claim_id}), 32'b110);
        en = 4'b1011;
        tick();
        check_eq("wd_irq", 32'(irq), 0);
        check_eq("wd_pend", 32'(pend), 32'b0100);
        tick();
        check_eq("wd_stay", 32'(irq), 0);
        en = 4'hF;
        tick();
        check_eq("wd_reoffer", 32'({irq, claim_id}), 32'b110);
        en = 4'b1011; claim = 1;
        tick();
        en = 4'hF; claim = 0; intr = 4'b0000;
        check_eq("wd_claim_insvc", 32'(insvc), 32'b0100);
        check_eq("wd_claim_pend", 32'(pend), 0);
        check_eq("wd_claim_irq", 32'(irq), 0);

        // Reset during an offer with sources 0 and 2 in service
        intr = 4'b0001; tick();
        intr = 4'b0000; tick();
        claim = 1; tick();
        claim = 0; intr = 4'b1000;
        tick(); tick();
        check_eq("mid_insvc", 32'(insvc), 32'b0101);
        check_eq("mid_offer", 32'({irq, claim_id}), 32'b111);
        rst = 1;
        tick();
        rst = 0;
        check_eq("mid_rst_all", 32'({irq, claim_id, pend, insvc, err}), 0);
        tick();
        check_eq("mid_repend", 32'(pend), 32'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
